// File: rtl/npu_slave_decoder.sv
// npu_slave_decoder: single-outstanding bus slave that decodes the NPU region map and issues one word access to the selected local SRAM
module npu_slave_decoder #(
    parameter int RD_LAT    = 1,
    parameter int OFS_W     = 12,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [3:0]           req_wstrb,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic                 mem_en,
    output logic [3:0]           mem_sel,
    output logic                 mem_we,
    output logic [OFS_W-1:0]     mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic [127:0]         mem_rdata,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    // NPU region map as absolute byte addresses; each END is exclusive
    localparam logic [31:0] NPU_BASE   = 32'h8200_0000;
    localparam logic [31:0] IMEM_START = NPU_BASE + 32'h0000_0000;
    localparam logic [31:0] IMEM_END   = NPU_BASE + 32'h0000_3100;
    localparam logic [31:0] WMEM_START = NPU_BASE + 32'h0000_3100;
    localparam logic [31:0] WMEM_END   = NPU_BASE + 32'h0000_6200;
    localparam logic [31:0] BMEM_START = NPU_BASE + 32'h0000_6200;
    localparam logic [31:0] BMEM_END   = NPU_BASE + 32'h0000_6280;
    localparam logic [31:0] OMEM_START = NPU_BASE + 32'h0000_6280;
    localparam logic [31:0] OMEM_END   = NPU_BASE + 32'h0000_8280;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [3:0]       hit;
    logic             dec_err;
    logic             accept;
    logic             rd_done;
    logic [31:0]      region_start;
    logic [OFS_W-1:0] ofs;
    logic             write_q;
    logic [3:0]       sel_q;
    logic [2:0]       wait_cnt;
    logic [31:0]      rd_slice;

    // Unsigned compares against absolute bounds, so nothing wraps past 0xFFFFFFFF
    assign hit[0]  = (req_addr >= IMEM_START) && (req_addr < IMEM_END);
    assign hit[1]  = (req_addr >= WMEM_START) && (req_addr < WMEM_END);
    assign hit[2]  = (req_addr >= BMEM_START) && (req_addr < BMEM_END);
    assign hit[3]  = (req_addr >= OMEM_START) && (req_addr < OMEM_END);
    assign dec_err = (hit == 4'b0000) || (req_addr[1:0] != 2'b00);

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = req_valid && req_ready;
    assign rd_done   = (state == S_WAIT) && (wait_cnt == 3'd0);

    // Start address of the hit region, used to form the word offset
    always_comb begin
        region_start = hit[0] ? IMEM_START :
                       hit[1] ? WMEM_START :
                       hit[2] ? BMEM_START : OMEM_START;
    end

    assign ofs = OFS_W'((req_addr - region_start) >> 2);

    // Pick the read word of the region latched at request time
    always_comb begin
        rd_slice = ({32{sel_q[0]}} & mem_rdata[31:0])
                 | ({32{sel_q[1]}} & mem_rdata[63:32])
                 | ({32{sel_q[2]}} & mem_rdata[95:64])
                 | ({32{sel_q[3]}} & mem_rdata[127:96]);
    end

    // Transaction sequencing: errors skip the memory, writes skip the wait
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = dec_err ? S_RESP : S_ISSUE;
            S_ISSUE: state_next = write_q ? S_RESP : S_WAIT;
            S_WAIT:  if (wait_cnt == 3'd0) state_next = S_RESP;
            S_RESP:  if (resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    // Remember direction and region for the cycles after the memory strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            write_q <= 1'b0;
            sel_q   <= 4'b0000;
        end else if (accept) begin
            write_q <= req_write;
            sel_q   <= hit;
        end
    end

    // Read latency down-counter: loaded on the strobe cycle, WAIT ends at zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                   wait_cnt <= 3'd0;
        else if (state == S_ISSUE)   wait_cnt <= 3'(RD_LAT - 1);
        else if (wait_cnt != 3'd0)   wait_cnt <= wait_cnt - 3'd1;
    end

    // Memory port: one registered strobe cycle per mapped request, zero otherwise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_en    <= 1'b0;
            mem_sel   <= 4'b0000;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
        end else if (accept && !dec_err) begin
            mem_en    <= 1'b1;
            mem_sel   <= hit;
            mem_we    <= req_write;
            mem_addr  <= ofs;
            mem_wdata <= req_wdata;
            mem_wstrb <= req_wstrb;
        end else begin
            mem_en    <= 1'b0;
            mem_sel   <= 4'b0000;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
        end
    end

    // Response register: loaded once per transaction, held until consumed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else if (accept && dec_err) begin
            resp_valid <= 1'b1;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b1;
        end else if (state == S_ISSUE && write_q) begin
            resp_valid <= 1'b1;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else if (rd_done) begin
            resp_valid <= 1'b1;
            resp_rdata <= rd_slice;
            resp_err   <= 1'b0;
        end else if (state == S_RESP && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // Saturating count of error responses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                              err_cnt <= '0;
        else if (accept && dec_err && err_cnt != {ERR_CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
    end

endmodule

// File: tb/tb_npu_slave_decoder.sv
// tb_npu_slave_decoder: directed bench with a cycle-level reference model for two decoder configurations
`timescale 1ns/1ps
module tb_npu_slave_decoder;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid [N];
    logic        req_write [N];
    logic        resp_ready[N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [3:0]  req_wstrb [N];
    logic [31:0] rd_word   [N];
    logic        req_ready [N];
    logic        resp_valid[N];
    logic        resp_err  [N];
    logic        mem_en    [N];
    logic        mem_we    [N];
    logic        busy      [N];
    logic [31:0] resp_rdata[N];
    logic [31:0] mem_wdata [N];
    logic [3:0]  mem_sel   [N];
    logic [3:0]  mem_wstrb [N];
    logic [11:0] mem_addr  [N];
    logic [15:0] err_cnt   [N];

    localparam logic [31:0] LO [4] = '{32'h8200_0000, 32'h8200_3100, 32'h8200_6200, 32'h8200_6280};
    localparam logic [31:0] HI [4] = '{32'h8200_3100, 32'h8200_6200, 32'h8200_6280, 32'h8200_8280};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void decode(input logic [31:0] a, output bit e, output logic [3:0] s, output logic [11:0] o);
        e = 1'b1;
        s = 4'b0;
        o = 12'h0;
        for (int i = 0; i < 4; i++)
            if (a >= LO[i] && a < HI[i] && a[1:0] == 2'b00) begin
                e = 1'b0;
                s = 4'b0001 << i;
                o = 12'((a - LO[i]) / 4);
            end
    endfunction

    for (genvar g = 0; g < N; g++) begin : u
        localparam int RL = (g == 0) ? 1 : 4;
        localparam int EW = (g == 0) ? 16 : 2;
        logic [127:0] mem_rdata;
        logic [EW-1:0] ec;
        int age;
        logic [3:0] rsel;
        bit pend, m_err, m_wr;
        int hs, lat, ecnt;
        logic [3:0] m_sel, m_ws;
        logic [11:0] m_ofs;
        logic [31:0] m_wd, m_rd;

        npu_slave_decoder #(.RD_LAT(RL), .OFS_W(12), .ERR_CNT_W(EW)) dut (
            .clk(clk), .rstn(rstn),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_wstrb(req_wstrb[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]), .resp_rdata(resp_rdata[g]),
            .resp_err(resp_err[g]), .mem_en(mem_en[g]), .mem_sel(mem_sel[g]), .mem_we(mem_we[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_wstrb(mem_wstrb[g]),
            .mem_rdata(mem_rdata), .busy(busy[g]), .err_cnt(ec)
        );
        assign err_cnt[g] = 16'(ec);

        // memory: valid word only in the data cycle RL cycles after the strobe cycle
        always @(posedge clk or negedge rstn)
            if (!rstn) begin
                age <= 0;
                rsel <= 4'b0;
            end else if (mem_en[g] && !mem_we[g]) begin
                age <= 1;
                rsel <= mem_sel[g];
            end else if (age != 0) begin
                age <= (age == RL) ? 0 : age + 1;
            end

        always_comb begin
            mem_rdata = '0;
            for (int i = 0; i < 4; i++)
                mem_rdata[32*i +: 32] = (age == RL && rsel[i]) ? rd_word[g] : (~rd_word[g] ^ {24'hA5A5A5, 8'(i)});
        end

        // reference model: one pending transaction with its predicted timeline
        always @(posedge clk or negedge rstn)
            if (!rstn) begin
                pend <= 1'b0;
                ecnt <= 0;
            end else if (pend) begin
                if (cyc >= hs + lat && resp_ready[g]) pend <= 1'b0;
            end else if (req_valid[g]) begin
                bit e;
                logic [3:0] s;
                logic [11:0] o;
                decode(req_addr[g], e, s, o);
                pend  <= 1'b1;
                hs    <= cyc;
                m_err <= e;
                m_wr  <= req_write[g];
                m_sel <= s;
                m_ofs <= o;
                m_wd  <= req_wdata[g];
                m_ws  <= req_wstrb[g];
                lat   <= e ? 1 : (req_write[g] ? 2 : RL + 2);
                m_rd  <= (e || req_write[g]) ? 32'h0 : rd_word[g];
                if (e && ecnt < (1 << EW) - 1) ecnt <= ecnt + 1;
            end

        always @(negedge clk)
            if (rstn) begin
                bit iss, ev;
                iss = pend && !m_err && (cyc == hs + 1);
                ev  = pend && (cyc >= hs + lat);
                chk($sformatf("d%0d.req_ready", g), req_ready[g], !pend);
                chk($sformatf("d%0d.busy", g), busy[g], pend);
                chk($sformatf("d%0d.mem_port", g),
                    {mem_en[g], mem_sel[g], mem_we[g], mem_addr[g], (iss && !m_wr) ? 36'h0 : {mem_wdata[g], mem_wstrb[g]}},
                    iss ? {1'b1, m_sel, m_wr, m_ofs, m_wr ? {m_wd, m_ws} : 36'h0} : 54'h0);
                chk($sformatf("d%0d.resp_valid", g), resp_valid[g], ev);
                if (ev) begin
                    chk($sformatf("d%0d.resp_rdata", g), resp_rdata[g], m_rd);
                    chk($sformatf("d%0d.resp_err", g), resp_err[g], m_err);
                end
                chk($sformatf("d%0d.err_cnt", g), err_cnt[g], ecnt);
            end
    end

    task automatic chk_reset(input int k);
        chk($sformatf("rst%0d.mem", k), {mem_en[k], mem_sel[k], mem_we[k], mem_addr[k], mem_wdata[k], mem_wstrb[k]}, 0);
        chk($sformatf("rst%0d.resp", k), {resp_valid[k], resp_err[k], resp_rdata[k]}, 0);
        chk($sformatf("rst%0d.busy_ready", k), {busy[k], req_ready[k]}, 2'b01);
        chk($sformatf("rst%0d.err_cnt", k), err_cnt[k], 0);
    endtask

    task automatic txn(input int k, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] rw, input logic [3:0] esel,
                       input logic [11:0] eofs, input bit eerr, input int elat,
                       input logic [31:0] erd, input int hold);
        int n, lat, en_n;
        logic [3:0] sel_s;
        logic [11:0] ofs_s;
        n = 0;
        lat = 0;
        en_n = 0;
        sel_s = 4'h0;
        ofs_s = 12'h0;
        rd_word[k] = rw;
        resp_ready[k] = (hold == 0);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k] = a;
        req_wdata[k] = wd;
        req_wstrb[k] = ws;
        @(negedge clk);
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("hs_wait %h", a), n < 50, 1'b1);
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_en[k]) begin
                en_n++;
                sel_s = mem_sel[k];
                ofs_s = mem_addr[k];
            end
        end while (!resp_valid[k] && lat < 20);
        chk($sformatf("latency %h", a), lat, elat);
        chk($sformatf("mem_en_pulses %h", a), en_n, eerr ? 0 : 1);
        chk($sformatf("sel %h", a), sel_s, esel);
        chk($sformatf("ofs %h", a), ofs_s, eofs);
        chk($sformatf("err %h", a), resp_err[k], eerr);
        chk($sformatf("rdata %h", a), resp_rdata[k], erd);
        if (hold > 0) begin
            req_valid[k] = 1'b1;
            req_write[k] = 1'b1;
            req_addr[k] = 32'h8200_0000;
            repeat (hold) begin
                @(negedge clk);
                chk("hold.valid_rdata", {resp_valid[k], resp_rdata[k]}, {1'b1, erd});
                chk("hold.ready", req_ready[k], 1'b0);
            end
            req_valid[k] = 1'b0;
            resp_ready[k] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int k = 0; k < N; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k] = 32'h0;
            req_wdata[k] = 32'h0;
            req_wstrb[k] = 4'h0;
            resp_ready[k] = 1'b1;
            rd_word[k] = 32'h0;
        end
        #12;
        chk_reset(0);
        chk_reset(1);
        @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        txn(0, 1, 32'h8200_3100, 32'hA5A5_0001, 4'hF, 32'h0, 4'b0010, 12'h000, 0, 2, 32'h0, 0);
        txn(0, 0, 32'h8200_30FC, 32'h0, 4'h0, 32'h1234_5678, 4'b0001, 12'hC3F, 0, 3, 32'h1234_5678, 0);
        txn(0, 0, 32'h8200_627C, 32'h0, 4'h0, 32'hCAFE_0001, 4'b0100, 12'h01F, 0, 3, 32'hCAFE_0001, 0);
        txn(0, 0, 32'h8200_6280, 32'h0, 4'h0, 32'hCAFE_0002, 4'b1000, 12'h000, 0, 3, 32'hCAFE_0002, 0);
        txn(0, 0, 32'h8200_61FC, 32'h0, 4'h0, 32'h0000_61FC, 4'b0010, 12'hC3F, 0, 3, 32'h0000_61FC, 0);
        txn(0, 0, 32'h8200_6200, 32'h0, 4'h0, 32'h0000_6200, 4'b0100, 12'h000, 0, 3, 32'h0000_6200, 0);
        txn(0, 0, 32'h8200_827C, 32'h0, 4'h0, 32'h0000_827C, 4'b1000, 12'h7FF, 0, 3, 32'h0000_827C, 0);
        txn(0, 0, 32'h8200_8280, 32'h0, 4'h0, 32'h1, 4'b0000, 12'h000, 1, 1, 32'h0, 0);
        txn(0, 0, 32'h8000_0000, 32'h0, 4'h0, 32'h2, 4'b0000, 12'h000, 1, 1, 32'h0, 0);
        txn(0, 1, 32'h8200_0002, 32'hFFFF_FFFF, 4'hF, 32'h3, 4'b0000, 12'h000, 1, 1, 32'h0, 0);
        chk("err_cnt_after_3", err_cnt[0], 16'd3);
        txn(0, 0, 32'h81FF_FFFC, 32'h0, 4'h0, 32'h4, 4'b0000, 12'h000, 1, 1, 32'h0, 0);
        txn(0, 0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h5, 4'b0000, 12'h000, 1, 1, 32'h0, 0);
        chk("err_cnt_after_5", err_cnt[0], 16'd5);
        txn(0, 0, 32'h8200_0010, 32'h0, 4'h0, 32'h0BAD_F00D, 4'b0001, 12'h004, 0, 3, 32'h0BAD_F00D, 10);
        txn(0, 1, 32'h8200_6284, 32'h1357_9BDF, 4'h3, 32'h0, 4'b1000, 12'h001, 0, 2, 32'h0, 0);

        txn(1, 0, 32'h8200_0000, 32'h0, 4'h0, 32'h7654_3210, 4'b0001, 12'h000, 0, 6, 32'h7654_3210, 0);
        for (int i = 0; i < 5; i++)
            txn(1, 0, 32'h8200_9000 + 32'(i), 32'h0, 4'h0, 32'h0, 4'b0000, 12'h000, 1, 1, 32'h0, 0);
        chk("err_cnt_saturated", err_cnt[1], 16'd3);

        rd_word[1] = 32'hDEAD_BEEF;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1] = 32'h8200_3104;
        n = 0;
        @(negedge clk);
        while (!req_ready[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_hs_wait", n < 50, 1'b1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_wait.busy", busy[1], 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk_reset(0);
        chk_reset(1);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst.no_resp", {resp_valid[1], mem_en[1]}, 2'b00);
        end
        @(posedge clk);
        #1;
        txn(1, 0, 32'h8200_6200, 32'h0, 4'h0, 32'h5555_AAAA, 4'b0100, 12'h000, 0, 6, 32'h5555_AAAA, 0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/npu_slave_decoder.md
Name: npu_slave_decoder

Overview:
Slave-side front end of the NPU core (Slave1). Accepts single-beat bus requests, decodes the absolute address against the NPU region bounds in pkg_memorymap (NPU_BASE + NPU_{IMEM,WMEM,BMEM,OMEM}_Start/End), and issues one word access to the selected local memory. It returns a read/write response, or an error for unmapped or misaligned addresses. It handles one outstanding transaction and sits between the system interconnect and the NPU local SRAMs.

Parameters:
RD_LAT, 1, memory read latency in cycles from the mem_en cycle to the data cycle; legal range 1..4
OFS_W, 12, width of the word offset inside a region; 0x3100 B / 4 = 0xC40 words
ERR_CNT_W, 16, width of the saturating decode-error counter

Ports:
clk  in  1  single clock, rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  32  absolute byte address
req_wdata  in  32  write data
req_wstrb  in  4  byte enables for writes
resp_valid  out  1  response valid
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_rdata  out  32  read data; 0 for writes and errors
resp_err  out  1  decode error
mem_en  out  1  one-cycle access strobe
mem_sel  out  4  one-hot region select: [0] IMEM, [1] WMEM, [2] BMEM, [3] OMEM
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  OFS_W  word offset = (req_addr - region_start) >> 2
mem_wdata  out  32  write data
mem_wstrb  out  4  byte enables
mem_rdata  in  128  packed read data, region i at [32*i+31:32*i]
busy  out  1  high whenever state != IDLE
err_cnt  out  ERR_CNT_W  saturating count of error responses

Behaviour:
- Reset (async assert, sync deassert sampled on clk): state IDLE; mem_en=0, mem_sel=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0; resp_valid=0, resp_rdata=0, resp_err=0; err_cnt=0; busy=0.
- Reset mid-transaction aborts the transaction. No mem_en is issued after reset, and a pending response is dropped.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- req_ready=1 only in IDLE.
- IDLE, on handshake: latch write, addr, wdata and wstrb, then decode combinationally from req_addr.
- Region hit: start <= addr < end, comparing 32-bit unsigned against the absolute bounds IMEM 0x82000000-0x820030FF, WMEM 0x82003100-0x820061FF, BMEM 0x82006200-0x8200627F, OMEM 0x82006280-0x8200827F.
- Error: no region hit, or addr[1:0] != 0. The error path goes IDLE -> RESP with resp_err=1, resp_rdata=0, no memory access. err_cnt increments when the error response is loaded and saturates at all-ones.
- Hit: IDLE -> ISSUE.
- ISSUE lasts exactly one cycle: mem_en=1, mem_sel, mem_addr, mem_we, mem_wdata and mem_wstrb are valid. All mem_* outputs are registered and return to 0 after this cycle.
- Write hit: ISSUE -> RESP with resp_rdata=0, resp_err=0.
- Read hit: ISSUE -> WAIT. WAIT lasts RD_LAT cycles via a down-counter. On the last WAIT cycle, the block samples the mem_rdata slice of the latched region into resp_rdata, then goes to RESP.
- RESP: resp_valid=1. resp_valid, resp_rdata and resp_err stay stable until resp_ready. On handshake, go to IDLE with resp_valid=0. A new request can be accepted on the cycle after that.
- Latency from request handshake edge to the first resp_valid cycle:
  - error: 1 cycle
  - write: 2 cycles
  - read: RD_LAT+2 cycles
- Boundaries:
  - the last byte of each region hits, and the next address decodes to the following region
  - 0x82008280 and beyond are errors
  - 0x80000000-0x81FFFFFF are errors
  - the 32-bit compare has no wrap-around; 0xFFFFFFFC is an error
- req_valid while not ready is ignored and nothing is latched. resp_ready outside RESP is ignored.

Test Plan:
- Write hit: write 0x82003100, wdata 0xA5A5_0001, wstrb 0xF -> ISSUE cycle with mem_sel=0010, mem_addr=0, mem_we=1; resp_valid 2 cycles after the handshake; resp_err=0, resp_rdata=0.
- Read hit, RD_LAT=1: read 0x820030FC, memory drives IMEM slice 0x1234_5678 in the data cycle -> mem_sel=0001, mem_addr=0xC3F; resp_valid 3 cycles after the handshake with rdata 0x1234_5678.
- Region boundaries: reads 0x8200627C and 0x82006280 -> mem_sel 0100 then 1000, mem_addr 0x1F then 0.
- Decode errors: addresses 0x82008280, 0x80000000 and 0x82000002 -> each gives resp_err=1 one cycle after the handshake, no mem_en pulse, err_cnt=3. With ERR_CNT_W=2, 5 errors leave err_cnt=3.
- Backpressure: hold resp_ready=0 for 10 cycles during a read response -> resp_valid and rdata stay stable, req_ready=0, a new req_valid is not accepted; the next transaction proceeds normally after resp_ready.
- Reset mid-read: RD_LAT=4, assert rstn low during WAIT -> all outputs are at reset values immediately; after release there is no resp_valid, and a fresh read completes correctly.
